// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/8 data/even parity/stop frames,
// with a ready/acknowledge holding register and parity/framing/overrun flags.
//
// state     | meaning
// IDLE      | line idle, waiting for rxd_s low
// START     | verifying start bit at mid-bit
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bit, delivering the byte
// WAIT_HIGH | line held low after frame, waiting for idle
module uart_rx #(
    parameter int OVS       = 16,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk_uart,
    input  logic       clrn,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] d_out,
    output logic       r_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       receiving
);

    localparam int              TW        = $clog2(OVS);
    localparam logic [TW-1:0]   TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t        state, state_nx;
    logic          rxd_m, rxd_s;
    logic [TW-1:0] tick, tick_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic          p_err, p_err_nx;
    logic          done;

    always_ff @(posedge clk_uart or negedge clrn) begin
        if (!clrn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk_uart or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            p_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
            p_err   <= p_err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tick_nx    = tick;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        p_err_nx   = p_err;
        done       = 1'b0;
        case (state)
            IDLE: begin
                tick_nx = '0;
                if (!rxd_s) state_nx = START;
            end
            START: begin
                if (tick == TICK_HALF) begin
                    tick_nx    = '0;
                    bit_cnt_nx = '0;
                    state_nx   = rxd_s ? IDLE : DATA;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            DATA: begin
                if (tick == TICK_LAST) begin
                    tick_nx    = '0;
                    shift_nx   = {rxd_s, shift[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = PARITY_EN ? PARITY : STOP;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            PARITY: begin
                if (tick == TICK_LAST) begin
                    tick_nx  = '0;
                    p_err_nx = (^shift) ^ rxd_s;
                    state_nx = STOP;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            STOP: begin
                if (tick == TICK_LAST) begin
                    tick_nx  = '0;
                    done     = 1'b1;
                    // a low stop bit may be a break; don't let it look like a new start
                    state_nx = rxd_s ? IDLE : WAIT_HIGH;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_uart or negedge clrn) begin
        if (!clrn) begin
            d_out      <= 8'h00;
            r_ready    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            receiving  <= 1'b0;
        end else begin
            receiving <= (state_nx == START) || (state_nx == DATA) ||
                         (state_nx == PARITY) || (state_nx == STOP);
            if (done) begin
                d_out      <= shift;
                parity_err <= PARITY_EN & p_err;
                frame_err  <= ~rxd_s;
                r_ready    <= 1'b1;
                if (r_ready && !rd_ack) overrun <= 1'b1;
                else if (rd_ack)        overrun <= 1'b0;
            end else if (rd_ack && r_ready) begin
                r_ready <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link; the receive-side counterpart of the transmitter. It recovers frames of the form [start, d0..d7, parity (even), stop] from the `rxd` line by 16x oversampling on the UART clock. Each received byte is presented on a holding register with a ready/acknowledge handshake toward the memory/CPU side. Parity, framing and overrun errors are flagged.

## Interface
- `OVS`, 16: clock cycles per bit (`clk_uart` = baud × OVS); even, ≥4
- `PARITY_EN`, 1: 1 = parity bit expected and checked (even); 0 = no parity bit
- `clk_uart`  input  1  oversampling clock, all logic on rising edge
- `clrn`  input  1  asynchronous active-low reset
- `rxd`  input  1  serial line, idle high, asynchronous to `clk_uart`
- `rd_ack`  input  1  consumer has taken `d_out`; clears `r_ready`/`overrun`
- `d_out`  output  8  last received byte
- `r_ready`  output  1  `d_out` holds an unread byte
- `parity_err`  output  1  parity mismatch on the byte in `d_out`
- `frame_err`  output  1  stop bit sampled low on the byte in `d_out`
- `overrun`  output  1  a byte was overwritten before being acknowledged
- `receiving`  output  1  frame in progress (LED indicator)

## Operation
- `rxd` passes through a 2-FF synchronizer (`rxd_s`); both FFs reset to 1.
- Counters: `tick` (0..OVS-1), `bit_cnt` (0..7), 8-bit `shift` register.
- The FSM has 6 states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: if `rxd_s`=0, go to START with `tick`=0.
- START: `tick` increments. At `tick`=OVS/2-1:
  - `rxd_s`=0: go to DATA with `tick`=0 and `bit_cnt`=0.
  - `rxd_s`=1: false start; return to IDLE with no output change.
- DATA: at `tick`=OVS-1, shift right with `rxd_s` into bit 7 (LSB first), then `tick`=0.
  - After the 8th sample, go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: at `tick`=OVS-1, capture `p`=`rxd_s`. The frame has a parity error if `^shift ^ p` = 1.
- STOP: at `tick`=OVS-1, on the same edge:
  - `d_out` ← `shift`.
  - `parity_err` ← computed value, or 0 if parity is disabled.
  - `frame_err` ← ~`rxd_s`.
  - `r_ready` ← 1.
  - `overrun` ← 1 if `r_ready` was 1 and `rd_ack`=0 on that edge, otherwise `overrun` ← 0 when `rd_ack`=1, else held.
  - Next state is IDLE if `rxd_s`=1, otherwise WAIT_HIGH.
- WAIT_HIGH: remain until `rxd_s`=1, then go to IDLE. This prevents a break or line-low condition from retriggering.
- `rd_ack` with `r_ready`=1 and no frame completing: `r_ready` ← 0 and `overrun` ← 0 on the next edge. The error flags hold until the next frame completes.
- `rd_ack` on the same edge as a frame completion: the new byte is loaded, `r_ready` stays 1 and `overrun` ← 0.
- `rd_ack` while `r_ready`=0: ignored.
- `receiving` = 1 in START, DATA, PARITY and STOP; 0 in IDLE and WAIT_HIGH.

## Timing
- Reset (async, `clrn`=0):
  - FSM = IDLE, all counters 0, `shift`=0.
  - `d_out`=0x00; `r_ready`, `parity_err`, `frame_err`, `overrun` and `receiving` all 0.
- Reset mid-frame aborts the frame immediately with no partial byte delivered. After reset release, the block waits in IDLE for a fresh falling edge.
- Sampling relative to edge k (first rising edge with `rxd`=0 seen by FF1):
  - `rxd_s`=0 at k+1; START entered at k+2.
  - Start bit verified at k+2+OVS/2.
  - Data bit i sampled at k+2+OVS/2+(i+1)·OVS.
- Outputs update at k+2+OVS/2+10·OVS with parity, or +9·OVS without. For OVS=16: k+170, or k+154 without parity.
- A low pulse shorter than OVS/2 cycles on `rxd_s` is rejected as a false start.
- All outputs are registered; no combinational path from `rxd` or `rd_ack` to any output.
- Back-to-back frames are accepted: the next start bit can be detected on the cycle after STOP exits.

## Test plan
- Byte 0x55, parity 0, stop 1, OVS=16: `d_out`=0x55 and `r_ready`=1 at k+170. Errors 0; `receiving` high from k+2 to k+170.
- Byte 0xA5 with parity bit 1 (wrong): `d_out`=0xA5, `parity_err`=1, `frame_err`=0. Then 0x01 with parity 1: `parity_err` returns to 0.
- 4-cycle low glitch on `rxd`: `receiving` rises for OVS/2 cycles then falls; `r_ready` stays 0. A following valid 0x3C is received correctly.
- 0x0F with stop bit 0 and line held low 40 bit-times: `frame_err`=1 and one byte delivered. FSM stays in WAIT_HIGH (`receiving`=0) until the line returns high; the next 0x81 frame is received clean.
- 0x11 then 0x22 with no `rd_ack`: `d_out`=0x22, `overrun`=1. Pulse `rd_ack`: `r_ready`=0 and `overrun`=0 next edge. Repeat with `rd_ack` coincident with completion: `r_ready` stays 1, `overrun`=0.
- Assert `clrn` during data bit 4 of 0xFF: all outputs 0 immediately. After release, the line is idle; the next 0x7E is received with `r_ready` at k+170.
